// File: rtl/dp_if.sv
// Memory bus between the datapath (master) and the program/data memory (slave).
// Read data returns in the cycle after the address is presented.
interface dp_if #(
    parameter int ADR_WIDTH  = 6,
    parameter int DATA_WIDTH = 8
);
    logic [ADR_WIDTH-1:0]  adr_o;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  we_o;
    logic [DATA_WIDTH-1:0] dat_i;

    modport master (output adr_o, output dat_o, output we_o, input dat_i);
    modport slave  (input adr_o, input dat_o, input we_o, output dat_i);
endinterface

// File: rtl/dp.sv
// Accumulator-machine datapath: PC, MAR, A, D and carry registers plus a NOR/ADD ALU.
// All sequencing decisions come from the external controller via the ctr_* enables.
module dp #(
    parameter int ADR_WIDTH  = 6,
    parameter int OP_WIDTH   = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ctr_marmux_i,
    input  logic [1:0]          ctr_carrymux_i,
    input  logic                ctr_pc_reg_en_i,
    input  logic                ctr_a_reg_en_i,
    input  logic                ctr_mar_reg_en_i,
    input  logic                ctr_d_reg_en_i,
    input  logic                ctr_we_i,
    input  logic [OP_WIDTH-1:0] ctr_aluop_i,
    dp_if.master                mem_if,
    output logic [OP_WIDTH-1:0] op_o,
    output logic                carry_o,
    output logic [ADR_WIDTH-1:0] pc_o
);

    typedef enum logic [1:0] {
        CARRY_KEEP  = 2'b00,
        CARRY_GEN   = 2'b01,
        CARRY_CLR   = 2'b10,
        CARRY_KEEP2 = 2'b11
    } carry_op_e;

    localparam logic [OP_WIDTH-1:0] ALU_NOR = '0;
    localparam logic [OP_WIDTH-1:0] ALU_ADD = OP_WIDTH'(1);

    logic [ADR_WIDTH-1:0]  r_pc;
    logic [ADR_WIDTH-1:0]  r_mar;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_d;
    logic                  r_c;

    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_alu_res;
    logic                  w_alu_co;
    carry_op_e             w_carry_op;

    assign w_carry_op = carry_op_e'(ctr_carrymux_i);
    assign w_sum      = {1'b0, r_a} + {1'b0, r_d};

    always_comb begin
        w_alu_res = r_a;
        w_alu_co  = r_c;
        if (ctr_aluop_i == ALU_NOR) begin
            w_alu_res = ~(r_a | r_d);
            w_alu_co  = 1'b0;
        end else if (ctr_aluop_i == ALU_ADD) begin
            w_alu_res = w_sum[DATA_WIDTH-1:0];
            w_alu_co  = w_sum[DATA_WIDTH];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc  <= '0;
            r_mar <= '0;
            r_a   <= '0;
            r_d   <= '0;
            r_c   <= 1'b0;
        end else begin
            if (ctr_pc_reg_en_i)
                r_pc <= r_mar + ADR_WIDTH'(1);
            if (ctr_mar_reg_en_i)
                r_mar <= ctr_marmux_i ? r_d[ADR_WIDTH-1:0] : r_pc;
            if (ctr_d_reg_en_i)
                r_d <= mem_if.dat_i;
            if (ctr_a_reg_en_i)
                r_a <= w_alu_res;
            // Carry follows its own select, even when A is not being loaded.
            case (w_carry_op)
                CARRY_GEN: r_c <= w_alu_co;
                CARRY_CLR: r_c <= 1'b0;
                default:   r_c <= r_c;
            endcase
        end
    end

    assign mem_if.adr_o = r_mar;
    assign mem_if.dat_o = r_a;
    assign mem_if.we_o  = ctr_we_i;
    assign op_o         = r_d[DATA_WIDTH-1 -: OP_WIDTH];
    assign carry_o      = r_c;
    assign pc_o         = r_pc;

endmodule

// File: doc/dp.md
DP -- requirements
Module: dp

Interface
REQ-001 Parameter ADR_WIDTH, default 6: memory address and instruction-argument width.
REQ-002 Parameter OP_WIDTH, default 2: opcode width.
REQ-003 Parameter DATA_WIDTH, default 8: word width; SHALL equal OP_WIDTH+ADR_WIDTH.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  reset; asynchronous and active-low.
REQ-006 ctr_marmux_i  in  1  MAR source select: 0 = PC, 1 = instruction argument.
REQ-007 ctr_carrymux_i  in  2  carry op: 00 keep, 01 generate, 10 clear, 11 keep.
REQ-008 ctr_pc_reg_en_i, ctr_a_reg_en_i, ctr_mar_reg_en_i, ctr_d_reg_en_i  in  1 each  register load enables.
REQ-009 ctr_we_i  in  1  memory write request from the controller.
REQ-010 ctr_aluop_i  in  OP_WIDTH  ALU op: 00 NOR, 01 ADD; 10 and 11 mean hold.
REQ-011 dat_i  in  DATA_WIDTH  memory read data; valid in the cycle after adr_o is presented.
REQ-012 adr_o  out  ADR_WIDTH  memory address, equal to the MAR register.
REQ-013 dat_o  out  DATA_WIDTH  memory write data, equal to the A register.
REQ-014 we_o  out  1  memory write enable, equal to ctr_we_i, combinational.
REQ-015 op_o  out  OP_WIDTH  opcode to controller, equal to D[DATA_WIDTH-1 -: OP_WIDTH].
REQ-016 carry_o  out  1  carry flag register, to the controller.
REQ-017 pc_o  out  ADR_WIDTH  PC register, for debug.

Function
REQ-018 Registers: PC (ADR_WIDTH), MAR (ADR_WIDTH), A (DATA_WIDTH), D (DATA_WIDTH), C (1 bit); no other state.
REQ-019 PC: when ctr_pc_reg_en_i=1, PC <= MAR+1 modulo 2^ADR_WIDTH; otherwise PC holds.
REQ-020 MAR: when ctr_mar_reg_en_i=1, MAR <= PC if ctr_marmux_i=0, else D[ADR_WIDTH-1:0]; otherwise MAR holds.
REQ-021 D: when ctr_d_reg_en_i=1, D <= dat_i; otherwise D holds.
REQ-022 ALU: ADD computes the (DATA_WIDTH+1)-bit sum A+D; its result is the low DATA_WIDTH bits and its carry-out is the MSB.
REQ-023 ALU: NOR computes ~(A|D) with carry-out 0; the hold ops (10, 11) give result = A and carry-out = C.
REQ-024 A: when ctr_a_reg_en_i=1, A <= ALU result; otherwise A holds.
REQ-025 C: generate loads the ALU carry-out, clear loads 0, keep/11 hold C.
REQ-026 C: carry updates are independent of ctr_a_reg_en_i.
REQ-027 Simultaneous enables: every register samples pre-edge values of the other registers.
- pc_en with mar_en: PC gets old MAR+1; MAR gets old PC.
- a_en with carry generate: both computed from the same old A and D.
REQ-028 Wrap: PC at 2^ADR_WIDTH-1 wraps to 0; ADD with A+D >= 2^DATA_WIDTH keeps the low bits and the carry-out is 1.
REQ-029 Write and read together: with we_o=1 and d_en=1 in one cycle, dat_o is old A and D gets dat_i.
REQ-030 No combinational path from dat_i to any output.

Reset
REQ-031 While rst_ni=0: PC, MAR, A, D and C are 0 immediately (asynchronous).
- Resulting outputs: adr_o=0, dat_o=0, op_o=0, carry_o=0, pc_o=0.
- we_o still follows ctr_we_i.
REQ-032 Reset release: the first update occurs on the first rising edge with rst_ni=1; asserting reset mid-instruction discards all state.

Verification
REQ-033 Fetch: MAR=5, pc_en=1, d_en=1, dat_i=8'h47 -> PC=6, D=8'h47, op_o=2'b01, adr_o=5.
REQ-034 ADD with carry generate: A=8'hF0, D=8'h20, a_en=1, aluop=01, carrymux=01 -> A=8'h10, carry_o=1.
REQ-035 NOR: A=8'h0F, D=8'h30, NOR with generate -> A=8'hC0, carry_o=0.
REQ-036 Clear then keep: clear -> carry_o=0; keep -> unchanged.
REQ-037 MAR and PC wrap: D=8'hBF, mar_en with marmux=1 -> MAR=6'h3F; next cycle pc_en -> PC=0; simultaneous pc_en and mar_en (marmux=0) -> swap of old values.
REQ-038 Async reset: drop rst_ni between clock edges with A=8'hAA and C=1 -> A=0 and carry_o=0 before the next edge; hold after release without enables -> values stay 0.
